// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - parametrised raster timing generator with delayed video syncs
//
// Ports:
//   Clock       pixel clock
//   Reset       synchronous reset, active-high
//   Enable      1 = run raster, 0 = hold at frame start
//   Base_Addr   framebuffer base, captured at frame start
//   Pix_X/Y     current h/v count (straight from the counter registers)
//   Pix_Valid   current position is inside the active area
//   Pix_Addr    framebuffer address of (Pix_X, Pix_Y), 0 outside active area
//   Sof         one-cycle pulse at (0,0)
//   Line_End    one-cycle pulse at the last active pixel of an active line
//   Frame_Count completed-frame counter
//   De/Hsync/Vsync  video controls delayed by PIPE_DELAY cycles
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int ADDR_W     = 19,
  parameter int STRIDE     = 640,
  parameter int PIPE_DELAY = 2,
  parameter int FC_W       = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic [ADDR_W-1:0] Base_Addr,
  output logic [X_W-1:0]    Pix_X,
  output logic [Y_W-1:0]    Pix_Y,
  output logic              Pix_Valid,
  output logic [ADDR_W-1:0] Pix_Addr,
  output logic              Sof,
  output logic              Line_End,
  output logic [FC_W-1:0]   Frame_Count,
  output logic              De,
  output logic              Hsync,
  output logic              Vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0]    H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]    H_ACT     = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]    H_ACT_END = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0]    HS_START  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]    HS_END    = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]    V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]    V_ACT     = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]    VS_START  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]    VS_END    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] STRIDE_A  = ADDR_W'(STRIDE);

  logic [X_W-1:0]    h_q, h_d;
  logic [Y_W-1:0]    v_q, v_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [FC_W-1:0]   fc_q, fc_d;
  // Set while the raster is parked: the next running cycle is a fresh frame
  // start and must take Base_Addr live, since no wrap edge has loaded it.
  logic              held_q, held_d;

  logic              run;
  logic              at_h_last;
  logic              at_v_last;
  logic [ADDR_W-1:0] addr_base;
  logic              raw_de;
  logic              raw_hs;
  logic              raw_vs;
  logic [2:0]        raw_sig;
  logic [2:0]        dly_sig;

  always_comb begin
    run       = Enable & ~Reset;
    at_h_last = (h_q == H_LAST);
    at_v_last = (v_q == V_LAST);
    // line_base_q doubles as the per-frame shadow of Base_Addr.
    addr_base = held_q ? Base_Addr : line_base_q;

    h_d         = h_q;
    v_d         = v_q;
    line_base_d = line_base_q;
    held_d      = held_q;
    fc_d        = fc_q;

    if (!run) begin
      h_d         = '0;
      v_d         = '0;
      line_base_d = '0;
      held_d      = 1'b1;
      if (Reset) begin
        fc_d = '0;
      end
    end else begin
      held_d = 1'b0;
      if (at_h_last) begin
        h_d = '0;
        if (at_v_last) begin
          v_d         = '0;
          line_base_d = Base_Addr;
          fc_d        = fc_q + 1'b1;
        end else begin
          v_d         = v_q + 1'b1;
          line_base_d = addr_base + STRIDE_A;
        end
      end else begin
        h_d         = h_q + 1'b1;
        line_base_d = addr_base;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      h_q         <= '0;
      v_q         <= '0;
      line_base_q <= '0;
      fc_q        <= '0;
      held_q      <= 1'b1;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      line_base_q <= line_base_d;
      fc_q        <= fc_d;
      held_q      <= held_d;
    end
  end

  always_comb begin
    raw_de  = run && (h_q < H_ACT) && (v_q < V_ACT);
    raw_hs  = run && (h_q >= HS_START) && (h_q < HS_END);
    raw_vs  = run && (v_q >= VS_START) && (v_q < VS_END);
    raw_sig = {raw_vs, raw_hs, raw_de};
  end

  assign Pix_X       = h_q;
  assign Pix_Y       = v_q;
  assign Pix_Valid   = raw_de;
  assign Pix_Addr    = raw_de ? (addr_base + ADDR_W'(h_q)) : '0;
  assign Sof         = run && (h_q == '0) && (v_q == '0);
  assign Line_End    = run && (h_q == H_ACT_END) && (v_q < V_ACT);
  assign Frame_Count = fc_q;

  // Control delay line, stored active-high; polarity applied at the pins.
  if (PIPE_DELAY == 0) begin : g_nodelay
    assign dly_sig = raw_sig;
  end else begin : g_delay
    logic [2:0] pipe_q [PIPE_DELAY];
    logic [2:0] pipe_d [PIPE_DELAY];

    always_comb begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_d[i] = '0;
      end
      if (run) begin
        pipe_d[0] = raw_sig;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < PIPE_DELAY; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end

    assign dly_sig = pipe_q[PIPE_DELAY-1];
  end

  assign De    = dly_sig[0];
  assign Hsync = (HSYNC_POL != 0) ? dly_sig[1] : ~dly_sig[1];
  assign Vsync = (VSYNC_POL != 0) ? dly_sig[2] : ~dly_sig[2];

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized model-based bench for video_timing_gen
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int STRIDE = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en;
  logic [AW-1:0] base;

  logic [2:0]    a_x, a_y, b_x, b_y;
  logic          a_valid, a_sof, a_le, a_de, a_hs, a_vs;
  logic          b_valid, b_sof, b_le, b_de, b_hs, b_vs;
  logic [AW-1:0] a_addr, b_addr;
  logic [1:0]    a_fc, b_fc;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(0), .VSYNC_POL(0), .X_W(3), .Y_W(3), .ADDR_W(AW),
    .STRIDE(STRIDE), .PIPE_DELAY(2), .FC_W(2)
  ) u_dut_a (
    .Clock(clk), .Reset(rst), .Enable(en), .Base_Addr(base),
    .Pix_X(a_x), .Pix_Y(a_y), .Pix_Valid(a_valid), .Pix_Addr(a_addr),
    .Sof(a_sof), .Line_End(a_le), .Frame_Count(a_fc),
    .De(a_de), .Hsync(a_hs), .Vsync(a_vs)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(1), .X_W(3), .Y_W(3), .ADDR_W(AW),
    .STRIDE(STRIDE), .PIPE_DELAY(0), .FC_W(2)
  ) u_dut_b (
    .Clock(clk), .Reset(rst), .Enable(en), .Base_Addr(base),
    .Pix_X(b_x), .Pix_Y(b_y), .Pix_Valid(b_valid), .Pix_Addr(b_addr),
    .Sof(b_sof), .Line_End(b_le), .Frame_Count(b_fc),
    .De(b_de), .Hsync(b_hs), .Vsync(b_vs)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: position within the frame as a flat cycle index,
  // the base captured for this frame, and a two-deep history of controls.
  int       pos        = 0;
  bit       held       = 1'b1;
  int       fc         = 0;
  int       frame_base = 0;
  bit [2:0] hist1      = '0;
  bit [2:0] hist2      = '0;

  task automatic step(input bit r, input bit e, input int b);
    bit       run, valid, sof, le, hs, vs;
    int       h, v, addr;
    bit [2:0] raw;
    rst  = r;
    en   = e;
    base = b[AW-1:0];
    @(negedge clk);
    run = e && !r;
    h   = pos % HT;
    v   = pos / HT;
    if (run && held) frame_base = b % (1 << AW);
    valid = run && h < HA && v < VA;
    addr  = valid ? (frame_base + v * STRIDE + h) % (1 << AW) : 0;
    sof   = run && pos == 0;
    le    = run && h == HA - 1 && v < VA;
    hs    = run && h >= HA + HF && h < HA + HF + HS;
    vs    = run && v >= VA + VF && v < VA + VF + VS;
    raw   = {vs, hs, valid};

    check("a_pix_x",   a_x, h);
    check("a_pix_y",   a_y, v);
    check("a_valid",   a_valid, valid);
    check("a_addr",    a_addr, addr);
    check("a_sof",     a_sof, sof);
    check("a_lineend", a_le, le);
    check("a_fcount",  a_fc, fc);
    check("a_de_d2",   a_de, hist2[0]);
    check("a_hsync_d2", a_hs, !hist2[1]);
    check("a_vsync_d2", a_vs, !hist2[2]);
    check("b_addr",    b_addr, addr);
    check("b_sof",     b_sof, sof);
    check("b_lineend", b_le, le);
    check("b_fcount",  b_fc, fc);
    check("b_de_d0",   b_de, valid);
    check("b_hsync_d0", b_hs, hs);
    check("b_vsync_d0", b_vs, vs);

    @(posedge clk);
    if (r) fc = 0;
    else if (run && pos == FT - 1) fc = (fc + 1) % 4;
    if (run && pos == FT - 1) frame_base = b % (1 << AW);
    if (run) begin
      hist2 = hist1;
      hist1 = raw;
      pos   = (pos + 1) % FT;
      held  = 1'b0;
    end else begin
      hist1 = '0;
      hist2 = '0;
      pos   = 0;
      held  = 1'b1;
    end
    #1;
  endtask

  initial begin
    int cur_base;
    rst  = 1'b1;
    en   = 1'b0;
    base = '0;
    @(posedge clk);
    #1;

    // Reset held with Enable high: parked, no Sof.
    repeat (3) step(1'b1, 1'b1, 'h100);

    // Five full frames; base moves to 0x200 during frame 1 (v=1).
    for (int c = 0; c < 5 * FT; c++) step(1'b0, 1'b1, (c >= FT + HT) ? 'h200 : 'h100);

    // Drop Enable at v=2, h=3 for five cycles, then resume.
    repeat (2 * HT + 3) step(1'b0, 1'b1, 'h200);
    repeat (5) step(1'b0, 1'b0, 'h300);
    repeat (30) step(1'b0, 1'b1, 'h300);

    // Reset mid-frame.
    repeat (2) step(1'b1, 1'b1, 'h340);
    repeat (60) step(1'b0, 1'b1, 'h340);

    // Randomized run: rare resets, occasional enable drops, wandering base.
    cur_base = 'h340;
    for (int c = 0; c < 2500; c++) begin
      int u;
      u = $urandom_range(0, 999);
      if ($urandom_range(0, 9) == 0) cur_base = $urandom_range(0, (1 << AW) - 1);
      step(u < 3, !(u >= 3 && u < 15), cur_base);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
